// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: a parallel pattern is accepted through a load/ready
// handshake and shifted out MSB-first on dout, one bit per clk, for repeat_n+1 passes.
module serial_pattern_gen #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             stop,
   output logic             ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [CNT_W-1:0] rep_cnt;

   // hold keeps the accepted pattern so every pass reloads it, independent of the inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         hold       <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         rep_cnt    <= '0;
         ready      <= 1'b1;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (load && !stop) begin
                  hold       <= pattern;
                  dout       <= pattern[WIDTH-1];
                  dout_valid <= 1'b1;
                  shreg      <= pattern << 1;
                  bit_cnt    <= LAST_IDX;
                  rep_cnt    <= repeat_n;
                  ready      <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SHIFT;
               end
            end

            SHIFT: begin
               if (stop) begin
                  dout       <= 1'b0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
                  ready      <= 1'b1;
                  shreg      <= '0;
                  bit_cnt    <= '0;
                  rep_cnt    <= '0;
                  state      <= IDLE;
               end else if (bit_cnt == '0) begin
                  // A pass just finished; start the next one with no gap bit, or wrap up.
                  if (rep_cnt != '0) begin
                     dout    <= hold[WIDTH-1];
                     shreg   <= hold << 1;
                     bit_cnt <= LAST_IDX;
                     rep_cnt <= rep_cnt - 1'b1;
                  end else begin
                     dout       <= 1'b0;
                     dout_valid <= 1'b0;
                     done       <= 1'b1;
                     shreg      <= '0;
                     state      <= DONE;
                  end
               end else begin
                  dout    <= shreg[WIDTH-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end

            default: begin
               dout       <= 1'b0;
               dout_valid <= 1'b0;
               done       <= 1'b0;
               busy       <= 1'b0;
               ready      <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
